aes_uart_sequencer: RTL
=======================

// Module: aes_uart_sequencer
// PURPOSE
//  Command sequencer between the UART byte link and the masked AES core inside the test harness.
//  Parses host byte commands, loads key, plaintext and mask seed, and starts one encryption.
//  Streams the 16-byte ciphertext back to the UART transmitter.
//  Drives the chip-level done indicator; the AES core has no other master.
// PARAMETERS
//  SEED_BYTES      4        mask-seed length in bytes (1..16); aes_seed width = 8*SEED_BYTES
//  TIMEOUT_CYCLES  4096     max cycles from aes_start to aes_done before error abort (>=2)
// PORTS
//  clk             in   1    single clock, all logic rising-edge
//  reset           in   1    asynchronous, active-high reset
//  rx_valid        in   1    one-cycle strobe: rx_data holds a received byte
//  rx_data         in   8    received byte
//  tx_data         out  8    byte to transmit
//  tx_valid        out  1    tx_data valid; held with tx_data stable until tx_ready
//  tx_ready        in   1    transmitter accepts byte when tx_valid&tx_ready
//  aes_key         out  128  key register to core
//  aes_plaintext   out  128  plaintext register to core
//  aes_seed        out  8*SEED_BYTES  mask-seed register to core
//  aes_start       out  1    one-cycle start pulse
//  aes_busy        in   1    core is encrypting
//  aes_done        in   1    one-cycle completion pulse; aes_ciphertext valid that cycle
//  aes_ciphertext  in   128  core result
//  done            out  1    high after a ciphertext is fully sent, until the next command byte
//  overrun         out  1    sticky: a byte arrived while not accepting; cleared only by reset
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; key/plaintext/seed/ct registers 0; byte counter 0.
//  Byte order: first data byte -> bits [MSB:MSB-7]; ciphertext sent MSB byte first.
//  Commands in IDLE: 0x4B 'K' +16 key bytes; 0x4D 'M' +SEED_BYTES seed bytes;
//    0x50 'P' +16 plaintext bytes, then encrypt. Any other byte -> send 0x3F '?'.
//  States: IDLE, LOAD_KEY, LOAD_SEED, LOAD_PT, START, WAIT, SEND, ERR.
//  IDLE: a command byte clears done and sets the counter to the byte count.
//  LOAD_*: each rx_valid shifts the byte in and decrements the counter.
//    After the last byte: K/M -> IDLE, P -> START.
//  START: entered the cycle after the last PT byte.
//    If aes_busy=0: aes_start=1 for exactly one cycle, then WAIT with the timeout counter cleared.
//    If aes_busy=1: stay in START with aes_start held 0.
//  WAIT: on aes_done, capture aes_ciphertext and go to SEND with index 0.
//    If the counter reaches TIMEOUT_CYCLES-1 first, go to ERR.
//  SEND: tx_valid=1, tx_data = ct byte[index]. Advance only on tx_valid&tx_ready.
//    After the 16th handshake: done=1 (next cycle) -> IDLE.
//  ERR: send 0x45 'E' under the same handshake, then IDLE; done stays 0.
//  '?' reply uses the same single-byte send path as ERR.
//  rx_valid in START/WAIT/SEND/ERR: byte dropped, overrun<=1. Loading bytes are never dropped.
//  aes_done outside WAIT: ignored. tx_ready without tx_valid: no effect.
//  No inter-byte timeout; a partial load waits indefinitely.
//  Async reset mid-operation:
//    aes_start and tx_valid drop immediately; partial load discarded; in-flight ciphertext lost.
//  Latency: last PT byte at cycle n -> aes_start at n+1 (core idle).
//    aes_done at m -> tx_valid at m+1.
// STRUCTURE
//  Shared package aes_seq_pkg: state enum, command codes CMD_KEY/CMD_SEED/CMD_PT,
//    reply codes RSP_UNKNOWN=8'h3F and RSP_ERR=8'h45, AES_BLOCK_BYTES=16.
//  One sub-module: aes_seq_shiftreg, a parameterised byte-wide load shift register.
//    Instantiated for key, plaintext and seed.
//  FSM, counters and the tx mux stay in the top module.
// TESTING
//  1 Send 'K'+000102..0F, 'P'+00112233..FF -> aes_key=0x000102..0F.
//    aes_plaintext=0x00112233..FF; one aes_start pulse one cycle after the last byte.
//  2 Model replies aes_done with ct=0x69C4E0D8..C55A -> tx bytes 69,C4,...,5A in order.
//    tx_ready toggled 50% random; done rises after the 16th handshake.
//  3 Send 'X' in IDLE -> single tx byte 0x3F; state returns to IDLE; done=0.
//  4 Model never asserts aes_done -> after TIMEOUT_CYCLES cycles, tx byte 0x45.
//    done=0; a new 'P' sequence then works.
//  5 rx_valid during WAIT -> overrun=1 and the byte is dropped.
//    A second aes_done pulse while in IDLE is ignored (no tx).
//  6 Assert reset mid-LOAD_PT (byte 7) and mid-SEND (byte 5) -> all outputs 0 immediately.
//    Registers cleared; the next full command sequence completes normally.

Source files
------------

// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES/UART command sequencer.
// Command and reply byte codes, FSM state encoding, ciphertext byte select.
package aes_seq_pkg;

    localparam int AES_BLOCK_BYTES = 16;

    localparam logic [7:0] CMD_KEY     = 8'h4B;  // 'K'
    localparam logic [7:0] CMD_SEED    = 8'h4D;  // 'M'
    localparam logic [7:0] CMD_PT      = 8'h50;  // 'P'
    localparam logic [7:0] RSP_UNKNOWN = 8'h3F;  // '?'
    localparam logic [7:0] RSP_ERR     = 8'h45;  // 'E'

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_KEY,
        ST_LOAD_SEED,
        ST_LOAD_PT,
        ST_START,
        ST_WAIT,
        ST_SEND,
        ST_ERR
    } seq_state_e;

    // Byte idx of a 128-bit block, idx 0 being the most significant byte.
    function automatic logic [7:0] ct_byte(input logic [127:0] blk, input logic [3:0] idx);
        return blk[127 - 8*int'(idx) -: 8];
    endfunction

endpackage

// File: rtl/aes_uart_sequencer_if.sv
// UART byte link and AES core signals seen by the sequencer.
// master = sequencer side, slave = UART/AES harness side.
interface aes_uart_sequencer_if #(
    parameter int SEED_BYTES = 4
);
    logic                    rx_valid;
    logic [7:0]              rx_data;
    logic [7:0]              tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic [127:0]            aes_key;
    logic [127:0]            aes_plaintext;
    logic [8*SEED_BYTES-1:0] aes_seed;
    logic                    aes_start;
    logic                    aes_busy;
    logic                    aes_done;
    logic [127:0]            aes_ciphertext;

    modport master (
        input  rx_valid, rx_data, tx_ready, aes_busy, aes_done, aes_ciphertext,
        output tx_data, tx_valid, aes_key, aes_plaintext, aes_seed, aes_start
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, aes_busy, aes_done, aes_ciphertext,
        input  tx_data, tx_valid, aes_key, aes_plaintext, aes_seed, aes_start
    );
endinterface

// File: rtl/aes_seq_shiftreg.sv
// Byte-wide load shift register: each load shifts a byte in at the LSB end,
// so the first byte of a full load ends up in the most significant byte.
module aes_seq_shiftreg #(
    parameter int BYTES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [7:0]         byte_i,
    output logic [8*BYTES-1:0] value_o
);

    logic [8*BYTES-1:0] value_q;
    logic [8*BYTES-1:0] value_d;

    if (BYTES == 1) begin : g_single
        assign value_d = byte_i;
    end else begin : g_multi
        assign value_d = {value_q[8*BYTES-9:0], byte_i};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else if (load_i) begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/aes_uart_sequencer.sv
// Host byte-command sequencer for the masked AES core: loads key/seed/plaintext,
// starts one encryption and streams the ciphertext (or a reply byte) to the UART.
module aes_uart_sequencer
    import aes_seq_pkg::*;
#(
    parameter int SEED_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    aes_uart_sequencer_if.master bus,
    output logic                 done,
    output logic                 overrun
);

    localparam int SEED_W = 8 * SEED_BYTES;
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES);

    seq_state_e         state_q;
    logic [4:0]         cnt_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [3:0]         idx_q;
    logic [127:0]       ct_q;
    logic [7:0]         rsp_q;
    logic               done_q;
    logic               overrun_q;

    logic               key_ld;
    logic               seed_ld;
    logic               pt_ld;
    logic               last_byte;
    logic [7:0]         tx_byte;
    logic [127:0]       key_w;
    logic [127:0]       pt_w;
    logic [SEED_W-1:0]  seed_w;

    assign key_ld    = (state_q == ST_LOAD_KEY)  && bus.rx_valid;
    assign seed_ld   = (state_q == ST_LOAD_SEED) && bus.rx_valid;
    assign pt_ld     = (state_q == ST_LOAD_PT)   && bus.rx_valid;
    assign last_byte = (cnt_q == 5'd1);

    aes_seq_shiftreg #(.BYTES(AES_BLOCK_BYTES)) u_key (
        .clk     (clk),
        .reset   (reset),
        .load_i  (key_ld),
        .byte_i  (bus.rx_data),
        .value_o (key_w)
    );

    aes_seq_shiftreg #(.BYTES(AES_BLOCK_BYTES)) u_pt (
        .clk     (clk),
        .reset   (reset),
        .load_i  (pt_ld),
        .byte_i  (bus.rx_data),
        .value_o (pt_w)
    );

    aes_seq_shiftreg #(.BYTES(SEED_BYTES)) u_seed (
        .clk     (clk),
        .reset   (reset),
        .load_i  (seed_ld),
        .byte_i  (bus.rx_data),
        .value_o (seed_w)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            idx_q     <= '0;
            ct_q      <= '0;
            rsp_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (bus.rx_valid && (state_q inside {ST_START, ST_WAIT, ST_SEND, ST_ERR})) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.rx_valid) begin
                        done_q <= 1'b0;
                        case (bus.rx_data)
                            CMD_KEY: begin
                                cnt_q   <= 5'(AES_BLOCK_BYTES);
                                state_q <= ST_LOAD_KEY;
                            end
                            CMD_SEED: begin
                                cnt_q   <= 5'(SEED_BYTES);
                                state_q <= ST_LOAD_SEED;
                            end
                            CMD_PT: begin
                                cnt_q   <= 5'(AES_BLOCK_BYTES);
                                state_q <= ST_LOAD_PT;
                            end
                            default: begin
                                rsp_q   <= RSP_UNKNOWN;
                                state_q <= ST_ERR;
                            end
                        endcase
                    end
                end

                ST_LOAD_KEY, ST_LOAD_SEED, ST_LOAD_PT: begin
                    if (bus.rx_valid) begin
                        cnt_q <= cnt_q - 5'd1;
                        if (last_byte) begin
                            state_q <= (state_q == ST_LOAD_PT) ? ST_START : ST_IDLE;
                        end
                    end
                end

                // aes_start is decoded from this state, so it can never outlast one cycle.
                ST_START: begin
                    if (!bus.aes_busy) begin
                        tmo_q   <= '0;
                        state_q <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (bus.aes_done) begin
                        ct_q    <= bus.aes_ciphertext;
                        idx_q   <= '0;
                        state_q <= ST_SEND;
                    end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_q   <= RSP_ERR;
                        state_q <= ST_ERR;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end

                ST_SEND: begin
                    if (bus.tx_ready) begin
                        if (idx_q == 4'(AES_BLOCK_BYTES - 1)) begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end

                ST_ERR: begin
                    if (bus.tx_ready) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: every variable assigned in always_comb gets a default first,
    // otherwise an unlisted case would infer a latch.
    always_comb begin
        tx_byte = 8'h00;
        case (state_q)
            ST_SEND: tx_byte = ct_byte(ct_q, idx_q);
            ST_ERR:  tx_byte = rsp_q;
            default: tx_byte = 8'h00;
        endcase
    end

    // Outputs decode directly from registers so async reset clears them at once.
    assign bus.tx_valid      = (state_q == ST_SEND) || (state_q == ST_ERR);
    assign bus.tx_data       = tx_byte;
    assign bus.aes_start     = (state_q == ST_START) && !bus.aes_busy;
    assign bus.aes_key       = key_w;
    assign bus.aes_plaintext = pt_w;
    assign bus.aes_seed      = seed_w;
    assign done              = done_q;
    assign overrun           = overrun_q;

endmodule
